// File: rtl/chn_sched_pkg.sv
// Shared types and helpers for the round-robin threshold scheduler.
package chn_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // The difference is two bits wider than BITS, so (value - threshold) can never overflow.
    localparam int DIFF_GROW = 2;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/chn_threshold_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit searching from ptr upward with wrap.
// Zero latency; any_req is low when nothing is requesting.
module rr_pick #(
    parameter int CHANNELS = 2,
    localparam int IW = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IW-1:0]       ptr,
    output logic [IW-1:0]       sel,
    output logic                any_req
);

    int idx;

    // Walk the search order from farthest to nearest so the nearest hit is written last.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % CHANNELS;
            if (req[idx]) begin
                sel     = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chn_threshold_sched.sv
// Shares one signed threshold comparator among CHANNELS requesters, round-robin.
// Four cycles per grant (IDLE, CAPTURE, COMPARE, DONE); req is held until its gnt pulse.
module chn_threshold_sched
    import chn_sched_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*(BITS+1)-1:0] chn_values,
    input  logic                         thr_wr,
    input  logic [BITS:0]                thr_din,
    output logic [BITS:0]                threshold,
    output logic [CHANNELS-1:0]          gnt,
    output logic                         valid,
    output logic [BITS+1:0]              diff,
    output logic [CHANNELS-1:0]          above,
    output logic                         busy
);

    localparam int DW = BITS + DIFF_GROW;
    localparam int IW = $clog2(CHANNELS);

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       sel_q;
    logic [IW-1:0]       pick_sel;
    logic                pick_any;
    logic signed [BITS:0] val_q;
    logic signed [BITS:0] thr_q;

    rr_pick #(
        .CHANNELS(CHANNELS)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .sel    (pick_sel),
        .any_req(pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            sel_q     <= '0;
            val_q     <= '0;
            thr_q     <= '0;
            threshold <= '0;
            gnt       <= '0;
            valid     <= 1'b0;
            diff      <= '0;
            above     <= '0;
            busy      <= 1'b0;
        end else begin
            gnt   <= '0;
            valid <= 1'b0;
            if (thr_wr) begin
                threshold <= thr_din;
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        sel_q <= pick_sel;
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Snapshot both operands so later input or threshold changes cannot leak in.
                    val_q <= chn_values[slice_lo(int'(sel_q), BITS + 1) +: BITS + 1];
                    thr_q <= threshold;
                    state <= COMPARE;
                end
                COMPARE: begin
                    diff         <= DW'(val_q) - DW'(thr_q);
                    above[sel_q] <= val_q > thr_q;
                    state        <= DONE;
                end
                DONE: begin
                    gnt[sel_q] <= 1'b1;
                    valid      <= 1'b1;
                    ptr        <= (sel_q == IW'(CHANNELS - 1)) ? '0 : sel_q + IW'(1);
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/chn_threshold_sched.md
Name: chn_threshold_sched

Overview:
Round-robin scheduler that shares one signed threshold comparator between CHANNELS requesters.
- Each channel presents a signed (BITS+1)-bit value.
- The block grants one channel at a time, snapshots its value and the threshold, and computes a widened signed difference.
- It records a per-channel "above threshold" flag and returns a grant/valid pulse.
- It also owns the configurable signed threshold register that feeds the per-channel datapath.

Parameters:
BITS, 8, channel value and threshold width is BITS+1 bits (signed two's complement).
CHANNELS, 2, number of requesting channels (>=2).

Ports:
clk  input  1  single clock, all logic on rising edge.
rstn  input  1  reset, synchronous, active-low.
req  input  CHANNELS  per-channel request level; held until matching gnt bit.
chn_values  input  CHANNELS*(BITS+1)  flattened signed channel values; channel i in bits [i*(BITS+1) +: BITS+1].
thr_wr  input  1  threshold write strobe.
thr_din  input  BITS+1  signed threshold write data.
threshold  output  BITS+1  signed current threshold register.
gnt  output  CHANNELS  one-hot, 1-cycle pulse marking the channel just served.
valid  output  1  1-cycle pulse, coincident with gnt.
diff  output  BITS+2  signed (value - threshold) of the last served channel.
above  output  CHANNELS  per-channel flag: 1 if last served value > threshold.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: rstn sampled low at a rising edge forces, on that edge:
  - state=IDLE, ptr=0;
  - threshold=0, gnt=0, valid=0, diff=0, above=0, busy=0.
  - This applies in any state; an in-flight transaction is dropped with no gnt/valid.
- FSM states: IDLE -> CAPTURE -> COMPARE -> DONE -> IDLE.
  - IDLE: if any req bit is set, select channel sel with round-robin priority and go to CAPTURE; otherwise stay.
  - CAPTURE: latch val_q = chn_values[sel] and thr_q = threshold register (value before this edge); go to COMPARE.
  - COMPARE: diff <= sign-extended val_q minus sign-extended thr_q, in BITS+2 bits (never overflows); above[sel] <= (val_q > thr_q), signed comparison; other above bits unchanged; go to DONE.
  - DONE: gnt[sel]=1, valid=1 for this one cycle; ptr <= (sel+1) mod CHANNELS; go to IDLE.
- Latency: req sampled in IDLE at edge t; gnt/valid high in the cycle after edge t+3. Minimum of 4 cycles per transaction, so back-to-back grants are 4 cycles apart.
- Round-robin selection: the first index with req set, searching ptr, ptr+1, ... with wrap modulo CHANNELS. Ties are impossible; a single requester is always served.
- Equality: value == threshold gives above=0 and diff=0.
- req deasserted after the IDLE decision: the transaction still completes using the captured value.
- Threshold register:
  - thr_wr updates threshold at any state on the next edge.
  - A compare always uses thr_q; a write coincident with the CAPTURE edge is not seen by that compare but is seen by the next one.
- chn_values changes after CAPTURE do not affect the in-flight result.
- gnt is one-hot or zero; gnt and valid are never high outside DONE.

Decomposition:
- Package chn_sched_pkg:
  - state enum (IDLE, CAPTURE, COMPARE, DONE), 2-bit encoding;
  - helper function for the channel-slice index;
  - localparam for the difference width (BITS+2).
- Sub-module rr_pick (combinational):
  - inputs: req, ptr; outputs: sel index and any flag;
  - parameterised by CHANNELS.
- The FSM, registers and subtractor stay in chn_threshold_sched.

Test Plan:
1. Reset: hold rstn=0 for 2 edges with req=all ones and thr_wr=1 -> threshold=0, gnt=0, valid=0, diff=0, above=0, busy=0.
2. Basic compare (BITS=8): write thr_din=-3, then assert req=01 with chn0=-2 -> gnt=01 and valid 4 cycles after req is first sampled, diff=+1, above=01; with chn0=-3 -> diff=0, above[0]=0.
3. Fairness: req=11 held continuously from ptr=0 -> gnt sequence 01, 10, 01, 10, 4 cycles apart, busy stays high except one IDLE cycle per transaction.
4. Extremes: threshold=-256, chn1=255 -> diff=+511, above[1]=1; threshold=255, chn1=-256 -> diff=-511, above[1]=0.
5. Threshold write timing: thr_wr with thr_din=10 on the CAPTURE edge, threshold previously 0, chn0=5 -> diff=+5, above[0]=1; next transaction with chn0=5 -> diff=-5, above[0]=0.
6. Mid-operation reset: rstn=0 for one edge while in COMPARE -> no gnt/valid pulse, all outputs zero, ptr=0; the next req=10 is served and gives gnt=10.
